// File: rtl/vga_framebuffer.sv
// Double-buffered 160x120x12 framebuffer feeding the VGA timing block.
// Display reads the front bank; drawing writes, clears and swaps the back bank.
module vga_framebuffer #(
  parameter int unsigned FB_W        = 160,
  parameter int unsigned FB_H        = 120,
  parameter int unsigned SCALE_SHIFT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [9:0]  row,
  input  logic [9:0]  col,
  input  logic        read,
  input  logic        vs,
  output logic [11:0] pix_data,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [7:0]  wr_x,
  input  logic [6:0]  wr_y,
  input  logic [11:0] wr_color,
  input  logic        clr_req,
  input  logic [11:0] clr_color,
  input  logic        swap_req,
  output logic        busy,
  output logic        swap_done,
  output logic        front_sel
);

  localparam int unsigned FB_WORDS = FB_W * FB_H;
  localparam int unsigned AW       = 15;
  localparam int unsigned CW       = 12;

  localparam logic [9:0]    DISP_W    = 10'(FB_W << SCALE_SHIFT);
  localparam logic [9:0]    DISP_H    = 10'(FB_H << SCALE_SHIFT);
  localparam logic [7:0]    FB_W_L    = 8'(FB_W);
  localparam logic [6:0]    FB_H_L    = 7'(FB_H);
  localparam logic [AW-1:0] LAST_ADDR = AW'(FB_WORDS - 1);

  typedef enum logic {S_IDLE, S_CLEAR} state_e;

  // Frame storage; contents are deliberately not reset.
  logic [CW-1:0] bank0 [FB_WORDS];
  logic [CW-1:0] bank1 [FB_WORDS];

  state_e        state_q, state_d;
  logic [AW-1:0] clr_addr_q, clr_addr_d;
  logic [CW-1:0] clr_color_q, clr_color_d;
  logic          front_sel_q, front_sel_d;
  logic          swap_pend_q, swap_pend_d;
  logic          swap_done_q, swap_done_d;
  logic          vs_d_q;
  logic [CW-1:0] pix_data_q, pix_data_d;

  logic [7:0]    fx_c, fy_c;
  logic [AW-1:0] raddr_c, wr_addr_c, waddr_c;
  logic [CW-1:0] wdata_c;
  logic          we_c, wr_in_range_c, vs_rise_c, visible_c;

  // Address generation: row/col scaled down, addr = y*160 + x via shifts.
  always_comb begin
    fx_c          = 8'(col >> SCALE_SHIFT);
    fy_c          = 8'(row >> SCALE_SHIFT);
    raddr_c       = (AW'(fy_c) << 7) + (AW'(fy_c) << 5) + AW'(fx_c);
    wr_addr_c     = (AW'(wr_y) << 7) + (AW'(wr_y) << 5) + AW'(wr_x);
    wr_in_range_c = (wr_x < FB_W_L) && (wr_y < FB_H_L);
    visible_c     = read && (row < DISP_H) && (col < DISP_W);
  end

  // Next-state: clear sequencer, write acceptance, swap arbitration, pixel fetch.
  always_comb begin
    state_d     = state_q;
    clr_addr_d  = clr_addr_q;
    clr_color_d = clr_color_q;
    front_sel_d = front_sel_q;
    swap_pend_d = swap_pend_q;
    swap_done_d = 1'b0;
    wr_ready    = 1'b0;
    we_c        = 1'b0;
    waddr_c     = wr_addr_c;
    wdata_c     = wr_color;
    vs_rise_c   = vs && !vs_d_q;

    unique case (state_q)
      S_IDLE: begin
        wr_ready = !clr_req;
        if (clr_req) begin
          state_d     = S_CLEAR;
          clr_color_d = clr_color;
          clr_addr_d  = '0;
        end else if (wr_valid && wr_in_range_c) begin
          we_c = 1'b1;
        end
      end
      S_CLEAR: begin
        we_c    = 1'b1;
        waddr_c = clr_addr_q;
        wdata_c = clr_color_q;
        if (clr_addr_q == LAST_ADDR) begin
          state_d = S_IDLE;
        end else begin
          clr_addr_d = clr_addr_q + AW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A request arriving on the swap edge itself only arms the next frame.
    if (vs_rise_c && swap_pend_q && (state_q == S_IDLE)) begin
      front_sel_d = !front_sel_q;
      swap_pend_d = 1'b0;
      swap_done_d = 1'b1;
    end else if (swap_req) begin
      swap_pend_d = 1'b1;
    end

    pix_data_d = '0;
    if (visible_c) begin
      pix_data_d = front_sel_q ? bank1[raddr_c] : bank0[raddr_c];
    end

    if (rst) begin
      wr_ready = 1'b0;
      we_c     = 1'b0;
    end
  end

  // Control and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      clr_addr_q  <= '0;
      clr_color_q <= '0;
      front_sel_q <= 1'b0;
      swap_pend_q <= 1'b0;
      swap_done_q <= 1'b0;
      vs_d_q      <= 1'b0;
      pix_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      clr_addr_q  <= clr_addr_d;
      clr_color_q <= clr_color_d;
      front_sel_q <= front_sel_d;
      swap_pend_q <= swap_pend_d;
      swap_done_q <= swap_done_d;
      vs_d_q      <= vs;
      pix_data_q  <= pix_data_d;
    end
  end

  // Back-bank write port; the bank is chosen by the pre-toggle front_sel.
  always_ff @(posedge clk) begin
    if (we_c) begin
      if (front_sel_q) begin
        bank0[waddr_c] <= wdata_c;
      end else begin
        bank1[waddr_c] <= wdata_c;
      end
    end
  end

  assign pix_data  = pix_data_q;
  assign busy      = (state_q == S_CLEAR);
  assign swap_done = swap_done_q;
  assign front_sel = front_sel_q;

endmodule

// File: tb/tb_vga_framebuffer.sv
// Self-checking bench for vga_framebuffer against a frame-array reference model.
module tb_vga_framebuffer;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  row, col;
  logic        read, vs;
  logic [11:0] pix_data;
  logic        wr_valid, wr_ready;
  logic [7:0]  wr_x;
  logic [6:0]  wr_y;
  logic [11:0] wr_color;
  logic        clr_req;
  logic [11:0] clr_color;
  logic        swap_req, busy, swap_done, front_sel;

  int checks = 0;
  int errors = 0;

  // Reference: two 160x120 frames and which one is on screen.
  logic [11:0] m [2][19200];
  int          m_front = 0;

  always #5 clk = ~clk;

  vga_framebuffer dut (
    .clk(clk), .rst(rst), .row(row), .col(col), .read(read), .vs(vs),
    .pix_data(pix_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_x(wr_x), .wr_y(wr_y), .wr_color(wr_color), .clr_req(clr_req),
    .clr_color(clr_color), .swap_req(swap_req), .busy(busy),
    .swap_done(swap_done), .front_sel(front_sel)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [11:0] exp_pix(int r, int c, bit rd);
    if (!rd || r >= 480 || c >= 640) return 12'h000;
    return m[m_front][(r / 4) * 160 + (c / 4)];
  endfunction

  function automatic void model_fill(int b, logic [11:0] c);
    for (int i = 0; i < 19200; i++) m[b][i] = c;
  endfunction

  // Raise vs for two cycles and count swap_done pulses seen around it.
  task automatic pulse_vs(output int n_done);
    n_done = 0;
    vs = 1'b1; tick(); if (swap_done === 1'b1) n_done++;
    tick();            if (swap_done === 1'b1) n_done++;
    vs = 1'b0; tick(); if (swap_done === 1'b1) n_done++;
    tick();            if (swap_done === 1'b1) n_done++;
  endtask

  // One write beat; returns wr_ready as seen before the edge and updates the model.
  task automatic do_write(int x, int y, logic [11:0] c, output logic rdy);
    wr_valid = 1'b1; wr_x = 8'(x); wr_y = 7'(y); wr_color = c;
    #1;
    rdy = wr_ready;
    tick();
    wr_valid = 1'b0;
    if (rdy === 1'b1 && x < 160 && y < 120) m[1 - m_front][y * 160 + x] = c;
  endtask

  task automatic test_reset();
    rst = 1'b1; read = 1'b1; row = 10'd20; col = 10'd40;
    tick(); tick(); tick();
    checks++; if (front_sel !== 1'b0) begin errors++; $display("FAIL reset_front_sel: got %b exp 0", front_sel); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b exp 0", busy); end
    checks++; if (swap_done !== 1'b0) begin errors++; $display("FAIL reset_swap_done: got %b exp 0", swap_done); end
    checks++; if (pix_data !== 12'h000) begin errors++; $display("FAIL reset_pix: got %h exp 000", pix_data); end
    rst = 1'b0; read = 1'b0;
    #1;
    checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL reset_wr_ready: got %b exp 1", wr_ready); end
    m_front = 0;
  endtask

  task automatic test_clear();
    int n_busy = 0;
    int n_rdy  = 0;
    int n_done;
    int cx[4] = '{0, 159, 80, 3};
    int cy[4] = '{0, 119, 60, 3};
    logic [11:0] exp;
    // clr_req and a write collide: clear wins.
    clr_req = 1'b1; clr_color = 12'h00F;
    wr_valid = 1'b1; wr_x = 8'd3; wr_y = 7'd3; wr_color = 12'hABC;
    #1;
    checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL clr_prio_ready: got %b exp 0", wr_ready); end
    tick();
    clr_req = 1'b0; wr_valid = 1'b0; clr_color = 12'h555;
    while (busy === 1'b1 && n_busy < 20000) begin
      #1;
      if (wr_ready !== 1'b0) n_rdy++;
      n_busy++;
      tick();
    end
    checks++; if (n_busy != 19200) begin errors++; $display("FAIL clear_busy_cycles: got %0d exp 19200", n_busy); end
    checks++; if (n_rdy != 0) begin errors++; $display("FAIL clear_wr_ready: got %0d ready cycles exp 0", n_rdy); end
    #1;
    checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL clear_ready_after: got %b exp 1", wr_ready); end
    model_fill(1 - m_front, 12'h00F);

    swap_req = 1'b1; tick(); swap_req = 1'b0;
    pulse_vs(n_done);
    checks++; if (n_done != 1) begin errors++; $display("FAIL clear_swap_done: got %0d pulses exp 1", n_done); end
    checks++; if (front_sel !== 1'b1) begin errors++; $display("FAIL clear_front_sel: got %b exp 1", front_sel); end
    m_front = 1;

    for (int i = 0; i < 4; i++) begin
      row = 10'(cy[i] * 4 + int'($urandom_range(0, 3)));
      col = 10'(cx[i] * 4 + int'($urandom_range(0, 3)));
      read = 1'b1;
      exp = exp_pix(int'(row), int'(col), read);
      tick();
      checks++; if (pix_data !== exp) begin errors++; $display("FAIL clear_corner%0d: got %h exp %h", i, pix_data, exp); end
    end
    read = 1'b0;
  endtask

  task automatic test_deferred_swap();
    int n_done;
    int guard = 0;
    logic [11:0] c = 12'($urandom);
    clr_req = 1'b1; clr_color = c; tick(); clr_req = 1'b0;
    repeat (100) tick();
    swap_req = 1'b1; tick(); swap_req = 1'b0;
    repeat (50) tick();
    swap_req = 1'b1; tick(); swap_req = 1'b0;
    pulse_vs(n_done);
    checks++; if (n_done != 0) begin errors++; $display("FAIL defer_mid_clear_done: got %0d exp 0", n_done); end
    checks++; if (front_sel !== 1'b1) begin errors++; $display("FAIL defer_mid_clear_front: got %b exp 1", front_sel); end
    while (busy === 1'b1 && guard < 20000) begin tick(); guard++; end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL defer_busy_timeout: got %b exp 0", busy); end
    model_fill(1 - m_front, c);
    pulse_vs(n_done);
    checks++; if (n_done != 1) begin errors++; $display("FAIL defer_swap_done: got %0d exp 1", n_done); end
    checks++; if (front_sel !== 1'b0) begin errors++; $display("FAIL defer_front: got %b exp 0", front_sel); end
    m_front = 0;
    pulse_vs(n_done);
    checks++; if (n_done != 0) begin errors++; $display("FAIL double_swap_done: got %0d exp 0", n_done); end
    checks++; if (front_sel !== 1'b0) begin errors++; $display("FAIL double_swap_front: got %b exp 0", front_sel); end
  endtask

  task automatic test_write_display();
    int n_done;
    int n_busy_rdy = 0;
    logic rdy;
    logic [11:0] exp;
    // Back-to-back random writes into the back bank.
    for (int i = 0; i < 200; i++) begin
      do_write(int'($urandom_range(0, 159)), int'($urandom_range(0, 119)), 12'($urandom), rdy);
      if (rdy !== 1'b1) n_busy_rdy++;
    end
    checks++; if (n_busy_rdy != 0) begin errors++; $display("FAIL b2b_wr_ready: got %0d stalls exp 0", n_busy_rdy); end
    do_write(10, 5, 12'hF0A, rdy);
    checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL wr_ready_main: got %b exp 1", rdy); end
    do_write(11, 5, 12'h123, rdy);
    do_write(160, 0, 12'hEEE, rdy);
    checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL drop_x_ready: got %b exp 1", rdy); end
    do_write(0, 120, 12'hDDD, rdy);
    checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL drop_y_ready: got %b exp 1", rdy); end
    do_write(200, 100, 12'hCCC, rdy);

    swap_req = 1'b1; tick(); swap_req = 1'b0;
    pulse_vs(n_done);
    checks++; if (n_done != 1) begin errors++; $display("FAIL wd_swap_done: got %0d exp 1", n_done); end
    checks++; if (front_sel !== 1'b1) begin errors++; $display("FAIL wd_front: got %b exp 1", front_sel); end
    m_front = 1;

    read = 1'b1;
    for (int r = 20; r < 24; r++) begin
      for (int c = 40; c < 45; c++) begin
        row = 10'(r); col = 10'(c);
        tick();
        exp = (c == 44) ? 12'h123 : 12'hF0A;
        checks++; if (pix_data !== exp) begin errors++; $display("FAIL disp_r%0d_c%0d: got %h exp %h", r, c, pix_data, exp); end
      end
    end
    // Pixels that a non-dropped out-of-range write would have hit.
    row = 10'd4; col = 10'd0; exp = exp_pix(4, 0, 1'b1); tick();
    checks++; if (pix_data !== exp) begin errors++; $display("FAIL drop_alias_0_1: got %h exp %h", pix_data, exp); end
    row = 10'd404; col = 10'd160; exp = exp_pix(404, 160, 1'b1); tick();
    checks++; if (pix_data !== exp) begin errors++; $display("FAIL drop_alias_40_101: got %h exp %h", pix_data, exp); end
    // Random pipelined reads across visible and blanking area.
    for (int i = 0; i < 300; i++) begin
      row  = 10'($urandom_range(0, 520));
      col  = 10'($urandom_range(0, 700));
      read = ($urandom_range(0, 3) != 0);
      exp  = exp_pix(int'(row), int'(col), read);
      tick();
      checks++; if (pix_data !== exp) begin errors++; $display("FAIL rand_read%0d: got %h exp %h", i, pix_data, exp); end
    end
    read = 1'b0;
  endtask

  task automatic test_blanking();
    logic [11:0] exp;
    read = 1'b0; row = 10'd20; col = 10'd40; tick();
    checks++; if (pix_data !== 12'h000) begin errors++; $display("FAIL blank_read0: got %h exp 000", pix_data); end
    read = 1'b1; col = 10'h3F0; tick();
    checks++; if (pix_data !== 12'h000) begin errors++; $display("FAIL blank_col_wrap: got %h exp 000", pix_data); end
    col = 10'd40; row = 10'd500; tick();
    checks++; if (pix_data !== 12'h000) begin errors++; $display("FAIL blank_row500: got %h exp 000", pix_data); end
    row = 10'd480; tick();
    checks++; if (pix_data !== 12'h000) begin errors++; $display("FAIL blank_row480: got %h exp 000", pix_data); end
    row = 10'd20; col = 10'd640; tick();
    checks++; if (pix_data !== 12'h000) begin errors++; $display("FAIL blank_col640: got %h exp 000", pix_data); end
    row = 10'd479; col = 10'd639; exp = exp_pix(479, 639, 1'b1); tick();
    checks++; if (pix_data !== exp) begin errors++; $display("FAIL edge_479_639: got %h exp %h", pix_data, exp); end
    read = 1'b0;
  endtask

  task automatic test_reset_mid_clear();
    int n_done;
    logic [11:0] exp;
    swap_req = 1'b1; clr_req = 1'b1; clr_color = 12'h0F0;
    tick();
    swap_req = 1'b0; clr_req = 1'b0;
    repeat (4999) tick();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rmc_busy_before: got %b exp 1", busy); end
    rst = 1'b1; read = 1'b1; row = 10'd20; col = 10'd40;
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmc_busy: got %b exp 0", busy); end
    checks++; if (front_sel !== 1'b0) begin errors++; $display("FAIL rmc_front: got %b exp 0", front_sel); end
    checks++; if (pix_data !== 12'h000) begin errors++; $display("FAIL rmc_pix: got %h exp 000", pix_data); end
    rst = 1'b0; read = 1'b0;
    m_front = 0;
    #1;
    checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL rmc_wr_ready: got %b exp 1", wr_ready); end
    pulse_vs(n_done);
    checks++; if (n_done != 0) begin errors++; $display("FAIL rmc_no_swap: got %0d exp 0", n_done); end
    checks++; if (front_sel !== 1'b0) begin errors++; $display("FAIL rmc_front_hold: got %b exp 0", front_sel); end
    swap_req = 1'b1; tick(); swap_req = 1'b0;
    pulse_vs(n_done);
    checks++; if (n_done != 1) begin errors++; $display("FAIL rmc_new_swap: got %0d exp 1", n_done); end
    m_front = 1;
    read = 1'b1; row = 10'd21; col = 10'd42; exp = exp_pix(21, 42, 1'b1); tick();
    checks++; if (pix_data !== exp) begin errors++; $display("FAIL rmc_read_after: got %h exp %h", pix_data, exp); end
    read = 1'b0;
  endtask

  initial begin
    rst = 1'b1; row = '0; col = '0; read = 1'b0; vs = 1'b0;
    wr_valid = 1'b0; wr_x = '0; wr_y = '0; wr_color = '0;
    clr_req = 1'b0; clr_color = '0; swap_req = 1'b0;
    test_reset();
    test_clear();
    test_deferred_swap();
    test_write_display();
    test_blanking();
    test_reset_mid_clear();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_framebuffer.md
Name: vga_framebuffer

Overview:
- Double-buffered 160x120x12-bit pixel store that sits directly upstream of the VGA timing block.
- Display side: takes the VGA block's registered row/col/read and returns the pixel colour on pix_data, which feeds the VGA block's Din.
- Draw side: game/drawing logic writes single pixels through a valid/ready port and can request a hardware clear of the back buffer and a frame-synchronised buffer swap.

Parameters:
- FB_W, 160, framebuffer width in pixels (display col >> 2).
- FB_H, 120, framebuffer height in pixels (display row >> 2).
- SCALE_SHIFT, 2, log2 of display-pixels per framebuffer pixel in each axis.

Ports:
- clk  in  1  pixel clock, same clock as the VGA block.
- rst  in  1  synchronous active-high reset.
- row  in  10  display row from the VGA block (0..479 visible; other values are blanking or wrapped).
- col  in  10  display column from the VGA block (0..639 visible).
- read  in  1  display-active strobe from the VGA block.
- vs  in  1  VS from the VGA block (high during vertical sync).
- pix_data  out  12  colour {B[11:8],G[7:4],R[3:0]} to the VGA block's Din.
- wr_valid  in  1  pixel write request.
- wr_ready  out  1  write accepted this cycle when high together with wr_valid.
- wr_x  in  8  write x coordinate.
- wr_y  in  7  write y coordinate.
- wr_color  in  12  write colour, same {B,G,R} packing.
- clr_req  in  1  one-cycle pulse: fill the back buffer with clr_color.
- clr_color  in  12  fill colour, sampled on the cycle clr_req is accepted.
- swap_req  in  1  one-cycle pulse: exchange front and back buffers at the next frame boundary.
- busy  out  1  high while a clear is in progress.
- swap_done  out  1  one-cycle pulse on the cycle the swap takes effect.
- front_sel  out  1  index of the buffer currently displayed.

Behaviour:
- Memory: two banks of FB_W*FB_H words × 12 bits. The read port serves the front bank and the write port serves the back bank, so reads and writes never conflict. Memory contents are not reset.
- Read path:
  - fx = col >> SCALE_SHIFT and fy = row >> SCALE_SHIFT.
  - addr = fy*160 + fx, computed as (fy<<7)+(fy<<5)+fx in 15 bits.
  - pix_data is registered and appears exactly 1 clk after row/col.
  - pix_data = 12'h000 if read was 0, or if col >= 640 or row >= 480 (this covers unsigned wrap from the VGA offset subtraction). Otherwise it equals front[addr].
  - The one-clock pixel lag is accepted and not compensated.
- State machine IDLE / CLEAR:
  - IDLE: wr_ready = !clr_req. busy = 0.
    - A write is accepted when wr_valid && wr_ready.
    - If wr_x < FB_W and wr_y < FB_H, back[wr_y*160+wr_x] <= wr_color on that edge. Out-of-range coordinates are accepted and dropped.
    - clr_req moves to CLEAR, latches clr_color and sets clr_addr = 0. If wr_valid is high in the same cycle, clr_req wins and the write is not accepted (wr_ready = 0).
  - CLEAR: writes the latched colour to back[clr_addr] and increments clr_addr each clk. busy = 1, wr_ready = 0.
    - After writing address 19199, returns to IDLE on the next edge; the clear takes 19200 cycles.
    - clr_req during CLEAR is ignored.
- Swap:
  - swap_req sets swap_pend. A second swap_req while pending has no effect.
  - vs_rise = vs && !vs_d, where vs_d is vs registered.
  - On vs_rise with swap_pend=1 and state=IDLE: toggle front_sel, clear swap_pend, and pulse swap_done for exactly 1 clk.
  - If state=CLEAR at vs_rise, the swap waits for the first vs_rise after the clear completes.
  - swap_req and vs_rise in the same cycle: swap_pend is set but does not swap until the next vs_rise.
  - A write accepted on the swap cycle goes to the old back bank, i.e. the bank selected before the toggle.
- Reset (synchronous, whole block):
  - State returns to IDLE; front_sel=0, swap_pend=0, swap_done=0, busy=0, pix_data=12'h000, vs_d=0.
  - A clear interrupted by rst is abandoned and the bank is left partially filled.
  - wr_ready becomes 1 on the first cycle after rst deasserts.

Test Plan:
- Write and display: write (10,5)=12'hF0A, swap_req, wait for vs_rise → swap_done pulses once and front_sel=1. When row=20..23 and col=40..43 with read=1, pix_data=12'hF0A one clk after row/col; adjacent col=44 shows the other stored value.
- Blanking and wrap: read=0, or col=10'h3F0 (wrapped), or row=500 → pix_data=12'h000 regardless of memory contents.
- Clear: clr_req with clr_color=12'h00F → busy=1 for exactly 19200 cycles and wr_ready=0 throughout. After swap, every visible pixel reads 12'h00F (sample corners (0,0), (159,119) and (80,60)).
- Priority and drop: clr_req and wr_valid in the same cycle → wr_ready=0, and the write is absent after the clear. A write to (160,0) or (0,120) is accepted with wr_ready=1 and changes no memory word.
- Deferred swap: swap_req during CLEAR with a vs_rise mid-clear → no toggle at that edge; toggle plus swap_done on the first vs_rise after busy falls. Double swap_req gives exactly one toggle.
- Reset mid-clear: assert rst at clear cycle 5000 → next cycle busy=0, wr_ready=1 after deassert, front_sel=0, pix_data=0, and no swap_done until a new swap_req and vs_rise.
